// File: rtl/ex_stage.sv
// Execute stage of the 5-stage MIPS pipeline: ID/EX register, ALU, data SRAM request,
// HI/LO registers and a 32-step restoring divider that stalls the pipe while it runs.
//   state    | meaning
//   DIV_IDLE | no divide in flight; a div/divu in EX starts one
//   DIV_BUSY | one shift-subtract step per cycle, stall requested
//   DIV_DONE | signed result ready; HI/LO written when EX/MEM advances
module ex_stage #(
  parameter int ID_TO_EX_WD  = 161,
  parameter int EX_TO_MEM_WD = 78,
  parameter int EX_TO_RF_WD  = 38,
  parameter int DIV_CYCLES   = 32
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [5:0]              stall,
  input  logic [ID_TO_EX_WD-1:0]  id_to_ex_bus,
  output logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
  output logic [EX_TO_RF_WD-1:0]  ex_to_rf_bus,
  output logic                    data_sram_en,
  output logic [3:0]              data_sram_wen,
  output logic [31:0]             data_sram_addr,
  output logic [31:0]             data_sram_wdata,
  output logic                    stallreq_for_ex
);

  localparam int CNT_W = $clog2(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIV_CYCLES - 1);

  typedef enum logic [1:0] {DIV_IDLE, DIV_BUSY, DIV_DONE} div_state_t;

  logic [ID_TO_EX_WD-1:0] ex_r;
  logic [1:0]  mem_op;
  logic [31:0] pc, inst, rdata1, rdata2;
  logic [11:0] alu_op;
  logic [2:0]  sel_src1;
  logic [3:0]  sel_src2, ram_wen;
  logic        ram_en, rf_we, sel_rf_res;
  logic [4:0]  rf_waddr;

  always_ff @(posedge clk) begin
    if (rst)                     ex_r <= '0;
    else if (stall[2] && !stall[3]) ex_r <= '0;
    else if (!stall[2])          ex_r <= id_to_ex_bus;
  end

  assign {mem_op, pc, inst, alu_op, sel_src1, sel_src2, ram_en, ram_wen,
          rf_we, rf_waddr, sel_rf_res, rdata1, rdata2} = ex_r;

  // operand select and ALU, all one-hot AND-OR muxes
  logic [31:0] src1, src2, alu_res;
  assign src1 = ({32{sel_src1[0]}} & rdata1)
              | ({32{sel_src1[1]}} & pc)
              | ({32{sel_src1[2]}} & {27'b0, inst[10:6]});
  assign src2 = ({32{sel_src2[0]}} & rdata2)
              | ({32{sel_src2[1]}} & {{16{inst[15]}}, inst[15:0]})
              | ({32{sel_src2[2]}} & 32'd8)
              | ({32{sel_src2[3]}} & {16'b0, inst[15:0]});

  logic [31:0] sra_res;
  assign sra_res = 32'($signed(src2) >>> src1[4:0]);

  assign alu_res = ({32{alu_op[11]}} & (src1 + src2))
                 | ({32{alu_op[10]}} & (src1 - src2))
                 | ({32{alu_op[9]}}  & {31'b0, $signed(src1) < $signed(src2)})
                 | ({32{alu_op[8]}}  & {31'b0, src1 < src2})
                 | ({32{alu_op[7]}}  & (src1 & src2))
                 | ({32{alu_op[6]}}  & ~(src1 | src2))
                 | ({32{alu_op[5]}}  & (src1 | src2))
                 | ({32{alu_op[4]}}  & (src1 ^ src2))
                 | ({32{alu_op[3]}}  & (src2 << src1[4:0]))
                 | ({32{alu_op[2]}}  & (src2 >> src1[4:0]))
                 | ({32{alu_op[1]}}  & sra_res)
                 | ({32{alu_op[0]}}  & {src2[15:0], 16'b0});

  logic is_special, is_mfhi, is_mflo, is_mthi, is_mtlo;
  logic is_mult, is_multu, is_divs, is_divu, is_div;
  assign is_special = (inst[31:26] == 6'b000000);
  assign is_mfhi  = is_special && (inst[5:0] == 6'b010000);
  assign is_mthi  = is_special && (inst[5:0] == 6'b010001);
  assign is_mflo  = is_special && (inst[5:0] == 6'b010010);
  assign is_mtlo  = is_special && (inst[5:0] == 6'b010011);
  assign is_mult  = is_special && (inst[5:0] == 6'b011000);
  assign is_multu = is_special && (inst[5:0] == 6'b011001);
  assign is_divs  = is_special && (inst[5:0] == 6'b011010);
  assign is_divu  = is_special && (inst[5:0] == 6'b011011);
  assign is_div   = is_divs || is_divu;

  // divider
  div_state_t div_state, div_next;
  logic [CNT_W-1:0] div_cnt;
  logic [31:0] div_rem, div_quo, div_dvs, q_fix, r_fix;
  logic        q_neg, r_neg, dvs_zero;
  logic [32:0] rem_sh, rem_diff;

  always_ff @(posedge clk) begin
    if (rst) div_state <= DIV_IDLE;
    else     div_state <= div_next;
  end

  always_comb begin
    div_next        = div_state;
    stallreq_for_ex = 1'b0;
    case (div_state)
      DIV_IDLE: if (is_div) begin
        stallreq_for_ex = 1'b1;
        div_next        = DIV_BUSY;
      end
      DIV_BUSY: begin
        stallreq_for_ex = 1'b1;
        if (div_cnt == CNT_LAST) div_next = DIV_DONE;
      end
      DIV_DONE: if (!stall[3]) div_next = DIV_IDLE;
      default:  div_next = DIV_IDLE;
    endcase
  end

  // borrow out of the 33-bit subtract means the shifted remainder is below the divisor
  assign rem_sh   = {div_rem, div_quo[31]};
  assign rem_diff = rem_sh - {1'b0, div_dvs};

  always_ff @(posedge clk) begin
    if (rst) begin
      div_cnt  <= '0;
      div_rem  <= '0;
      div_quo  <= '0;
      div_dvs  <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      dvs_zero <= 1'b0;
    end else if (div_state == DIV_IDLE && is_div) begin
      div_cnt  <= '0;
      div_rem  <= '0;
      div_quo  <= (is_divs && rdata1[31]) ? -rdata1 : rdata1;
      div_dvs  <= (is_divs && rdata2[31]) ? -rdata2 : rdata2;
      q_neg    <= is_divs && (rdata1[31] ^ rdata2[31]);
      r_neg    <= is_divs && rdata1[31];
      dvs_zero <= (rdata2 == 32'd0);
    end else if (div_state == DIV_BUSY) begin
      div_cnt <= div_cnt + 1'b1;
      if (!rem_diff[32]) begin
        div_rem <= rem_diff[31:0];
        div_quo <= {div_quo[30:0], 1'b1};
      end else begin
        div_rem <= rem_sh[31:0];
        div_quo <= {div_quo[30:0], 1'b0};
      end
    end
  end

  // a zero divisor leaves quotient all-ones and remainder equal to the dividend
  assign q_fix = dvs_zero ? 32'hFFFF_FFFF : (q_neg ? -div_quo : div_quo);
  assign r_fix = r_neg ? -div_rem : div_rem;

  // HI/LO
  logic [31:0] hi, lo;
  logic [63:0] prod_s, prod_u;
  assign prod_s = 64'($signed({{32{rdata1[31]}}, rdata1}) * $signed({{32{rdata2[31]}}, rdata2}));
  assign prod_u = {32'b0, rdata1} * {32'b0, rdata2};

  always_ff @(posedge clk) begin
    if (rst) begin
      hi <= '0;
      lo <= '0;
    end else if (!stall[3]) begin
      if (is_mthi)  hi <= rdata1;
      if (is_mtlo)  lo <= rdata1;
      if (is_mult)  {hi, lo} <= prod_s;
      if (is_multu) {hi, lo} <= prod_u;
      if (div_state == DIV_DONE && is_div) begin
        hi <= r_fix;
        lo <= q_fix;
      end
    end
  end

  logic [31:0] ex_result;
  assign ex_result = is_mfhi ? hi : (is_mflo ? lo : alu_res);

  assign ex_to_mem_bus = {mem_op, pc, ram_en, ram_wen, sel_rf_res, rf_we, rf_waddr, ex_result};
  assign ex_to_rf_bus  = {rf_we, rf_waddr, ex_result};

  assign data_sram_en    = ram_en;
  assign data_sram_wen   = (ram_wen != 4'b0000) ? 4'b1111 : 4'b0000;
  assign data_sram_addr  = alu_res;
  assign data_sram_wdata = rdata2;

  logic unused_bits;
  assign unused_bits = ^{inst[25:16], stall[5:4], stall[1:0]};

endmodule

// File: tb/tb_ex_stage.sv
// Directed bench for ex_stage: ALU ops, SRAM request, ID/EX stall/bubble,
// HI/LO moves, mult/multu, div/divu latency and results, reset mid-divide.
module tb_ex_stage;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [5:0]   stall = '0;
  logic [160:0] id_bus = '0;
  logic [77:0]  ex_to_mem_bus;
  logic [37:0]  ex_to_rf_bus;
  logic         data_sram_en;
  logic [3:0]   data_sram_wen;
  logic [31:0]  data_sram_addr, data_sram_wdata;
  logic         stallreq_for_ex;

  int n_checks = 0;
  int n_fail   = 0;

  localparam logic [31:0] PC = 32'hBFC0_0100;
  localparam logic [11:0] A_ADD = 12'b1000_0000_0000, A_SUB = 12'b0100_0000_0000,
                          A_SLT = 12'b0010_0000_0000, A_SLTU = 12'b0001_0000_0000,
                          A_AND = 12'b0000_1000_0000, A_NOR = 12'b0000_0100_0000,
                          A_OR  = 12'b0000_0010_0000, A_XOR = 12'b0000_0001_0000,
                          A_SLL = 12'b0000_0000_1000, A_SRL = 12'b0000_0000_0100,
                          A_SRA = 12'b0000_0000_0010, A_LUI = 12'b0000_0000_0001;
  localparam logic [31:0] I_MFHI = 32'h0000_2010, I_MFLO = 32'h0000_2012,
                          I_MTHI = 32'h0020_0011, I_MTLO = 32'h0020_0013,
                          I_MULT = 32'h0022_0018, I_MULTU = 32'h0022_0019,
                          I_DIV  = 32'h0022_001A, I_DIVU = 32'h0022_001B;

  ex_stage dut (
    .clk             (clk),
    .rst             (rst),
    .stall           (stall),
    .id_to_ex_bus    (id_bus),
    .ex_to_mem_bus   (ex_to_mem_bus),
    .ex_to_rf_bus    (ex_to_rf_bus),
    .data_sram_en    (data_sram_en),
    .data_sram_wen   (data_sram_wen),
    .data_sram_addr  (data_sram_addr),
    .data_sram_wdata (data_sram_wdata),
    .stallreq_for_ex (stallreq_for_ex)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [77:0] obs, input logic [77:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [160:0] mk(input logic [31:0] inst, input logic [11:0] alu,
                                      input logic [2:0] s1, input logic [3:0] s2,
                                      input logic ram_en, input logic [3:0] ram_wen,
                                      input logic rf_we, input logic [4:0] wa,
                                      input logic [31:0] r1, input logic [31:0] r2);
    return {2'b10, PC, inst, alu, s1, s2, ram_en, ram_wen, rf_we, wa, 1'b1, r1, r2};
  endfunction

  task automatic issue(input logic [160:0] b);
    id_bus = b;
    stall  = 6'b000000;
    tick();
  endtask

  task automatic alu_case(input string tag, input logic [31:0] inst, input logic [11:0] alu,
                          input logic [2:0] s1, input logic [3:0] s2,
                          input logic [31:0] r1, input logic [31:0] r2, input logic [31:0] exp);
    issue(mk(inst, alu, s1, s2, 1'b0, 4'b0, 1'b1, 5'd9, r1, r2));
    check(tag, ex_to_rf_bus, {1'b1, 5'd9, exp});
  endtask

  task automatic read_hilo(input string tag, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    issue(mk(I_MFLO, 12'b0, 3'b0, 4'b0, 1'b0, 4'b0, 1'b1, 5'd4, 32'd0, 32'd0));
    check({tag, "_lo"}, ex_to_rf_bus, {1'b1, 5'd4, exp_lo});
    issue(mk(I_MFHI, 12'b0, 3'b0, 4'b0, 1'b0, 4'b0, 1'b1, 5'd4, 32'd0, 32'd0));
    check({tag, "_hi"}, ex_to_rf_bus, {1'b1, 5'd4, exp_hi});
  endtask

  // div enters EX, is held while stallreq is high, then mflo/mfhi follow immediately
  task automatic run_div(input string tag, input logic [31:0] inst, input logic [31:0] r1,
                         input logic [31:0] r2, input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    issue(mk(inst, 12'b0, 3'b0, 4'b0, 1'b0, 4'b0, 1'b0, 5'd0, r1, r2));
    n = 0;
    while (stallreq_for_ex && n < 100) begin
      stall = 6'b001111;
      n++;
      tick();
    end
    check({tag, "_stall_cycles"}, 78'(n), 78'd33);
    read_hilo(tag, exp_hi, exp_lo);
  endtask

  initial begin
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    check("rst_rf_bus", ex_to_rf_bus, '0);
    check("rst_mem_bus", ex_to_mem_bus, '0);
    check("rst_sram", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}, '0);
    check("rst_stallreq", stallreq_for_ex, 1'b0);
    read_hilo("rst_hilo", 32'h0, 32'h0);

    // addu r3,r1,r2 wraps into the sign bit without trapping
    issue(mk(32'h0022_1821, A_ADD, 3'b001, 4'b0001, 1'b0, 4'b0, 1'b1, 5'd3, 32'h7FFF_FFFF, 32'd1));
    check("addu_rf", ex_to_rf_bus, {1'b1, 5'd3, 32'h8000_0000});
    check("addu_mem", ex_to_mem_bus, {2'b10, PC, 1'b0, 4'b0, 1'b1, 1'b1, 5'd3, 32'h8000_0000});
    check("addu_sram_en", data_sram_en, 1'b0);

    // ID/EX hold then bubble
    id_bus = mk(32'h0022_1823, A_SUB, 3'b001, 4'b0001, 1'b0, 4'b0, 1'b1, 5'd7, 32'd1, 32'd1);
    stall  = 6'b001111;
    tick();
    check("hold_rf", ex_to_rf_bus, {1'b1, 5'd3, 32'h8000_0000});
    stall = 6'b000111;
    tick();
    check("bubble_rf", ex_to_rf_bus, '0);
    check("bubble_mem", ex_to_mem_bus, '0);
    check("bubble_sram", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata}, '0);

    // sw / sb memory request
    issue(mk(32'hAC22_0004, A_ADD, 3'b001, 4'b0010, 1'b1, 4'b1111, 1'b0, 5'd0, 32'h100, 32'hDEAD_BEEF));
    check("sw_sram", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
          {1'b1, 4'hF, 32'h104, 32'hDEAD_BEEF});
    check("sw_rf", ex_to_rf_bus, {1'b0, 5'd0, 32'h104});
    issue(mk(32'hA022_FFFF, A_ADD, 3'b001, 4'b0010, 1'b1, 4'b0001, 1'b0, 5'd0, 32'h200, 32'h0000_00AB));
    check("sb_sram", {data_sram_en, data_sram_wen, data_sram_addr, data_sram_wdata},
          {1'b1, 4'hF, 32'h1FF, 32'h0000_00AB});

    alu_case("sub",   32'h0, A_SUB,  3'b001, 4'b0001, 32'd5,         32'd7,         32'hFFFF_FFFE);
    alu_case("slt",   32'h0, A_SLT,  3'b001, 4'b0001, 32'hFFFF_FFFF, 32'd1,         32'd1);
    alu_case("sltu",  32'h0, A_SLTU, 3'b001, 4'b0001, 32'hFFFF_FFFF, 32'd1,         32'd0);
    alu_case("and",   32'h0, A_AND,  3'b001, 4'b0001, 32'hF0F0_F0F0, 32'h3C3C_3C3C, 32'h3030_3030);
    alu_case("nor",   32'h0, A_NOR,  3'b001, 4'b0001, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'hF000_F000);
    alu_case("or",    32'h0, A_OR,   3'b001, 4'b0001, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'h0FFF_0FFF);
    alu_case("xor",   32'h0, A_XOR,  3'b001, 4'b0001, 32'h0F0F_0F0F, 32'h00FF_00FF, 32'h0FF0_0FF0);
    alu_case("sll",   32'h0000_0100, A_SLL, 3'b100, 4'b0001, 32'd0, 32'h8000_0001, 32'h0000_0010);
    alu_case("srl",   32'h0000_0100, A_SRL, 3'b100, 4'b0001, 32'd0, 32'h8000_0000, 32'h0800_0000);
    alu_case("sra",   32'h0000_0100, A_SRA, 3'b100, 4'b0001, 32'd0, 32'h8000_0000, 32'hF800_0000);
    alu_case("sllv",  32'h0, A_SLL,  3'b001, 4'b0001, 32'h0000_0024, 32'd1,         32'h0000_0010);
    alu_case("lui",   32'h3C01_1234, A_LUI, 3'b001, 4'b1000, 32'd0, 32'd0,         32'h1234_0000);
    alu_case("pc8",   32'h0, A_ADD,  3'b010, 4'b0100, 32'd0,         32'd0,         32'hBFC0_0108);
    alu_case("addi_neg", 32'h2021_FFFC, A_ADD, 3'b001, 4'b0010, 32'h100, 32'd0,     32'h0000_00FC);
    alu_case("ori_zext", 32'h3421_8001, A_OR, 3'b001, 4'b1000, 32'd0,  32'd0,       32'h0000_8001);
    alu_case("no_op", 32'h0, 12'b0, 3'b001, 4'b0001, 32'h1234_5678, 32'h1111_1111, 32'd0);

    // moves into HI/LO
    issue(mk(I_MTHI, 12'b0, 3'b0, 4'b0, 1'b0, 4'b0, 1'b0, 5'd0, 32'hAAAA_5555, 32'd0));
    issue(mk(I_MTLO, 12'b0, 3'b0, 4'b0, 1'b0, 4'b0, 1'b0, 5'd0, 32'h1357_9BDF, 32'd0));
    read_hilo("mthilo", 32'hAAAA_5555, 32'h1357_9BDF);

    run_div("div_m7_2",   I_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD);
    run_div("div_100_m7", I_DIV,  32'd100,       32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFF2);
    run_div("divu_zero",  I_DIVU, 32'h0000_1234, 32'd0,         32'h0000_1234, 32'hFFFF_FFFF);
    run_div("divu_big",   I_DIVU, 32'hFFFF_FFF9, 32'd2,         32'h0000_0001, 32'h7FFF_FFFC);

    // reset while divider is at counter 10
    issue(mk(I_DIV, 12'b0, 3'b0, 4'b0, 1'b0, 4'b0, 1'b0, 5'd0, 32'd1000, 32'd3));
    stall = 6'b001111;
    for (int i = 0; i < 11; i++) tick();
    check("busy_stallreq", stallreq_for_ex, 1'b1);
    rst = 1'b1;
    tick();
    check("rst_mid_stallreq", stallreq_for_ex, 1'b0);
    rst = 1'b0;
    read_hilo("rst_mid", 32'h0, 32'h0);

    issue(mk(I_MULT, 12'b0, 3'b0, 4'b0, 1'b0, 4'b0, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'd3));
    read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFD);
    issue(mk(I_MULTU, 12'b0, 3'b0, 4'b0, 1'b0, 4'b0, 1'b0, 5'd0, 32'hFFFF_FFFF, 32'd3));
    read_hilo("multu", 32'h0000_0002, 32'hFFFF_FFFD);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
